// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Mode encodings, display states and LED pattern helpers shared
//             by the LED pattern driver and its bench.
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_IRRIG = 2'b01;
    localparam logic [1:0] c_MODE_ALARM = 2'b10;
    localparam logic [1:0] c_MODE_SCAN  = 2'b11;

    localparam logic [3:0] c_PAT_OFF   = 4'b0000;
    localparam logic [3:0] c_PAT_ALT_A = 4'b0101;
    localparam logic [3:0] c_PAT_ALT_B = 4'b1010;
    localparam logic [3:0] c_PAT_ALL   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLINK = 2'd1,
        ST_ALARM = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        case (m)
            c_MODE_OFF:   s = ST_IDLE;
            c_MODE_IRRIG: s = ST_BLINK;
            c_MODE_ALARM: s = ST_ALARM;
            default:      s = ST_SCAN;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] led_pattern(input state_t s, input logic [2:0] ph);
        logic [3:0] p;
        case (s)
            ST_BLINK: p = {3'b000, ~ph[2]};
            ST_ALARM: p = ph[0] ? c_PAT_ALT_B : c_PAT_ALT_A;
            ST_SCAN:  p = 4'b0001 << ph[1:0];
            default:  p = c_PAT_OFF;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tick_sync
//  Purpose  : Two-flop synchronizer plus history flop; flags one rising edge
//             of an asynchronous level as a single-cycle rise.
//  Revision : 1.0  initial release
// ============================================================================
module tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // s3 clears on reset, so a level already high after reset counts as a rise
    assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/led_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_driver
//  Purpose  : Mode-driven LED pattern sequencer stepped by a divided LED clock,
//             with a watchdog that flags a stalled divider.
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int TIMEOUT = 131072,
    parameter int WD_W    = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkLeds,
    input  logic [1:0] mode,
    output logic [3:0] leds,
    output logic       tick,
    output logic       stall
);

    localparam logic [WD_W-1:0] c_WD_MAX = WD_W'(TIMEOUT);

    logic            w_rise;
    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_mode_state;
    logic [2:0]      r_phase;
    logic [2:0]      w_phase_nxt;
    logic [WD_W-1:0] r_wd;
    logic [WD_W-1:0] w_wd_nxt;
    logic            w_stall_nxt;
    logic [3:0]      w_leds_nxt;
    logic [3:0]      r_leds;
    logic            r_tick;
    logic            r_stall;

    tick_sync u_tick_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (clkLeds),
        .rise     (w_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= 3'd0;
            r_wd    <= '0;
            r_leds  <= c_PAT_OFF;
            r_tick  <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_wd    <= w_wd_nxt;
            r_leds  <= w_leds_nxt;
            r_tick  <= w_rise;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_mode_state = mode_to_state(mode);
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;

        // A mode change takes priority over a coincident rise and restarts the pattern
        if (w_mode_state != r_state) begin
            w_state_nxt = w_mode_state;
            w_phase_nxt = 3'd0;
        end else if (w_rise && (r_state != ST_IDLE)) begin
            w_phase_nxt = r_phase + 3'd1;
        end

        if (w_rise) begin
            w_wd_nxt = '0;
        end else if (r_wd == c_WD_MAX) begin
            w_wd_nxt = r_wd;
        end else begin
            w_wd_nxt = r_wd + 1'b1;
        end

        w_stall_nxt = !w_rise && (r_wd == c_WD_MAX);

        if (w_stall_nxt && (w_state_nxt != ST_IDLE)) begin
            w_leds_nxt = c_PAT_ALL;
        end else begin
            w_leds_nxt = led_pattern(w_state_nxt, w_phase_nxt);
        end
    end

    assign leds  = r_leds;
    assign tick  = r_tick;
    assign stall = r_stall;

endmodule
`default_nettype wire

// File: doc/led_pattern_driver.md
LED_PATTERN_DRIVER -- requirements
Module: led_pattern_driver

Interface
REQ-001 Parameter TIMEOUT, default 131072, is the number of clk cycles without a divided-clock rising edge before stall is flagged (two periods of a 2^16 divider).
REQ-002 Parameter WD_W, default 18, is the watchdog counter width; it SHALL hold TIMEOUT.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clkLeds  input  1  divided LED clock from the ripple divider; asynchronous to clk.
REQ-006 mode  input  2  display mode: 00 OFF, 01 IRRIG, 10 ALARM, 11 SCAN.
REQ-007 leds  output  4  LED pattern, registered.
REQ-008 tick  output  1  one-clk pulse per clkLeds rising edge, registered.
REQ-009 stall  output  1  high while no clkLeds edge has arrived within TIMEOUT cycles, registered.

Function
REQ-010 clkLeds SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-011 tick SHALL be high for exactly one clk cycle, after the third rising clk edge that samples clkLeds high (fixed latency 3 cycles); it SHALL never be high two consecutive cycles.
REQ-012 A 3-bit phase counter SHALL increment on each rise, wrapping 7 -> 0.
REQ-013 FSM states IDLE, BLINK, ALARM, SCAN; mode 00/01/10/11 maps to IDLE/BLINK/ALARM/SCAN.
REQ-014 When registered mode differs from current state, the next edge SHALL load the mapped state and clear phase to 0; leds SHALL reflect the new state one cycle later.
REQ-015 Mode change and rise in the same cycle: mode change wins, phase = 0; rise still pulses tick and clears the watchdog.
REQ-016 IDLE: leds = 0000, phase held at 0.
REQ-017 BLINK: leds = {000, ~phase[2]} (4 ticks on, 4 off).
REQ-018 ALARM: leds = 0101 when phase[0] = 0, 1010 when phase[0] = 1.
REQ-019 SCAN: leds = 0001 << phase[1:0] (0001, 0010, 0100, 1000, repeat).
REQ-020 leds SHALL be a registered function of next state and next phase, updating the cycle after any state/phase change.
REQ-021 The watchdog counter SHALL clear on rise, otherwise increment, saturating at TIMEOUT (no wrap).
REQ-022 stall SHALL assert the cycle after the counter reaches TIMEOUT and deassert the cycle after the next rise.
REQ-023 While stall = 1, leds SHALL be forced to 1111 in every state except IDLE.
REQ-024 Mode values are always legal; no X-propagation beyond the synchronizer.

Reset
REQ-025 On reset: s1 = s2 = s3 = 0, state = IDLE, phase = 0, watchdog = 0, leds = 0000, tick = 0, stall = 0.
REQ-026 Reset mid-operation SHALL take effect on the next clk edge, regardless of pending rise or mode change.
REQ-027 After reset, clkLeds already high SHALL produce one tick (s3 = 0 and s2 rising to 1 is a rise).

Structure
REQ-028 Shared package led_pkg SHALL hold mode encodings, state enumeration, and pattern constants 0101/1010/1111.
REQ-029 Synchronizer and edge detector SHALL be a sub-module, tick_sync (ports clk, reset, async_in, rise).
REQ-030 No derived clocks inside the block; clkLeds is used only as data.

Verification (TIMEOUT = 16, WD_W = 5 in simulation)
REQ-031 Reset, clkLeds = 0, mode = 11 -> leds = 0000, tick = 0, stall = 0; first edge out of reset loads SCAN, leds = 0001.
REQ-032 mode = 11, clkLeds square wave, period 40 clk -> tick every 40 cycles, 3 cycles after each rise; leds 0001, 0010, 0100, 1000, 0001 on successive ticks.
REQ-033 mode = 10, five clkLeds rises -> leds alternate 0101/1010 per tick; after eight rises phase wraps to 0 and leds = 0101.
REQ-034 Hold clkLeds low 16 cycles in BLINK -> stall = 1 and leds = 1111 on cycle 17; next rise -> stall = 0, BLINK pattern resumes.
REQ-035 Mode change from 01 to 11 in the same cycle as rise -> phase = 0, leds = 0001, tick pulses once, watchdog = 0.
REQ-036 Assert reset for 1 cycle mid-SCAN with leds = 0100 -> next cycle all outputs at reset values; clkLeds held high -> exactly one tick after release.
